mult_share_arbiter: RTL
=======================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 10, operand width; product width is 2*WIDTH.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_a  input  NREQ*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NREQ*WIDTH  packed operand B, same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; requester i's transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_r.
REQ-012 rsp_r  output  2*WIDTH  unsigned product.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, CALC, HOLD; one operation in flight at a time.
REQ-015 IDLE: if any req_valid is high, assert req_ready combinationally to exactly one requester chosen round-robin, capture its a, b and index into the operand register, and go to CALC; otherwise stay in IDLE.
REQ-016 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-017 CALC: drive the captured operands into one combinational multiplier instance, register the product and id into the result register, set rsp_valid, and go to HOLD.
REQ-018 HOLD: hold rsp_valid, rsp_id and rsp_r stable until rsp_ready is high; on that cycle clear rsp_valid and go to IDLE.
REQ-019 No grant in CALC or HOLD; req_ready is all-zero outside IDLE.
REQ-020 Latency: transfer at cycle T gives rsp_valid high from cycle T+2; minimum issue interval is 3 cycles.
REQ-021 Arithmetic is unsigned, full precision with no truncation: rsp_r = a*b exactly, range 0..(2^WIDTH-1)^2.
REQ-022 A requester dropping req_valid while not granted is legal and has no effect.
REQ-023 rsp_ready high while rsp_valid is low is ignored.
REQ-024 Only requester 0 valid, repeatedly: it is granted every issue slot, so round-robin never starves a sole requester.

Reset
REQ-025 While rst is high at a clock edge: state goes to IDLE, rsp_valid=0, rsp_id=0, rsp_r=0, busy=0, and last_grant=NREQ-1 so requester 0 has first priority.
REQ-026 req_ready is forced to all-zero during any cycle in which rst is high.
REQ-027 Reset mid-operation (CALC or HOLD) discards the in-flight result without asserting rsp_valid.

Structure
REQ-028 The state encoding (IDLE/CALC/HOLD) and the default WIDTH/NREQ constants reside in a shared package, mult_pkg.
REQ-029 The block contains one sub-module instance, multiplier #(WIDTH), with ports a, b, r, fed from the operand register.
REQ-030 The round-robin grant logic is local combinational logic, not a separate module.

Verification
REQ-031 Single request: req_valid=0001, a=1023, b=1023 -> req_ready=0001 for one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_r=1046529.
REQ-032 All four requesters valid continuously, rsp_ready tied high -> grant order 0,1,2,3,0; each rsp_r equals that requester's a*b.
REQ-033 Backpressure: rsp_ready held low for 10 cycles after rsp_valid rises -> rsp_r/rsp_id stable, req_ready=0 throughout, next grant occurs the cycle after rsp_ready rises.
REQ-034 Zero/edge operands: (0,1023)->0, (1,1)->1, (512,2)->1024, all with the correct rsp_id.
REQ-035 rst pulsed during HOLD -> rsp_valid=0 next cycle, busy=0, next grant goes to requester 0.
REQ-036 Exhaustive: all 2^10 x 2^10 operand pairs issued through rotating requesters and compared against a*b -> zero mismatches, bench prints SUCCESS.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants, FSM encoding and index helper for the shared-multiplier arbiter.
package mult_pkg;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // (base + off) mod n for base < n and 0 < off <= n, without a divider
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned full-precision combinational multiplier: r = a * b with a 2*WIDTH result.
module multiplier #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] r
);

  assign r = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters; one operation
// in flight, result held until the consumer accepts it.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*WIDTH-1:0]       rsp_r,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0] rsp_r_q, rsp_r_d;

  logic               grant_found_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [IDW-1:0]     cand_s;
  logic [NREQ-1:0]    grant_onehot_s;
  logic [NREQ-1:0]    req_ready_s;
  logic [2*WIDTH-1:0] prod_s;

  multiplier #(.WIDTH(WIDTH)) u_mult (
    .a (a_q),
    .b (b_q),
    .r (prod_s)
  );

  // Round-robin search: first valid requester after last_grant, wrapping around
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    cand_s        = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s        = IDW'(wrap_add(int'(last_grant_q), k, NREQ));
      grant_idx_s   = (req_valid[cand_s] && !grant_found_s) ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_s];
    end
    grant_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
  end

  // Next-state, capture and result-register logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;
    req_ready_s  = {NREQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s  = grant_onehot_s;
          a_d          = req_a[grant_idx_s*WIDTH +: WIDTH];
          b_d          = req_b[grant_idx_s*WIDTH +: WIDTH];
          id_d         = grant_idx_s;
          last_grant_d = grant_idx_s;
          state_d      = ST_CALC;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_CALC: begin
        rsp_r_d     = prod_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_HOLD;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, operand and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      id_q         <= {IDW{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= {IDW{1'b0}};
      rsp_r_q      <= {(2*WIDTH){1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
    end
  end

  assign req_ready = rst ? {NREQ{1'b0}} : req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
